// File: rtl/lifo_pkg.sv
// ----------------------------------------------------------------------------
// lifo_pkg
// Shared defaults and sizing helpers for the LIFO block.
//   DEF_SIZEDATA  : default data word width in bits
//   DEF_DEPTHLIFO : default number of storage entries (must be >= 2)
//   cnt_width()   : width of a counter that must hold 0..depth inclusive
//   addr_width()  : width of an index that must address 0..depth-1
// ----------------------------------------------------------------------------
package lifo_pkg;

   localparam int DEF_SIZEDATA  = 32;
   localparam int DEF_DEPTHLIFO = 8;

   // The occupancy counter must represent "full", i.e. the value depth
   // itself, which is why the argument is depth+1 rather than depth.
   function automatic int cnt_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

   // An index into a depth-entry array; never narrower than one bit.
   function automatic int addr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage : lifo_pkg

// File: rtl/lifo_mem.sv
// ----------------------------------------------------------------------------
// lifo_mem
// DEPTHLIFO x SIZEDATA register array used as LIFO storage.
// One synchronous write port and one combinational read port.
//   clk_i    : clock, writes happen on its rising edge
//   i_we     : write enable
//   i_waddr  : write index
//   i_wdata  : write data
//   i_raddr  : read index
//   o_rdata  : read data, combinational from i_raddr and array contents
// ----------------------------------------------------------------------------
module lifo_mem
   import lifo_pkg::*;
#(
   parameter int SIZEDATA  = DEF_SIZEDATA,
   parameter int DEPTHLIFO = DEF_DEPTHLIFO,
   parameter int ADDRW     = addr_width(DEPTHLIFO)
) (
   input  logic                clk_i,
   input  logic                i_we,
   input  logic [ADDRW-1:0]    i_waddr,
   input  logic [SIZEDATA-1:0] i_wdata,
   input  logic [ADDRW-1:0]    i_raddr,
   output logic [SIZEDATA-1:0] o_rdata
);

   logic [SIZEDATA-1:0] r_mem [DEPTHLIFO];

   // NOTE: the array has no reset on purpose; validity of each entry is
   // tracked by the stack pointer in the parent, so clearing the words would
   // only add a reset net fan-out to every storage bit for no functional gain.
   always_ff @(posedge clk_i) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : lifo_mem

// File: rtl/lifo.sv
// ----------------------------------------------------------------------------
// lifo
// Show-ahead last-in-first-out buffer with valid/ready handshakes on both
// sides, synchronous flush and asynchronous active-low reset.
//   clk_i   : clock, all state updates on its rising edge
//   rstn_i  : asynchronous active-low reset, empties the stack immediately
//   flush_i : synchronous clear, overrides push and pop in the same cycle
//   valid_i : push request
//   data_i  : push data
//   ready_o : push accepted when high (= !full_o)
//   valid_o : top entry available (= !empty_o)
//   data_o  : current top-of-stack word, don't-care while empty
//   ready_i : pop request
//   count_o : current occupancy, 0..DEPTHLIFO
//   full_o  : occupancy == DEPTHLIFO
//   empty_o : occupancy == 0
// ----------------------------------------------------------------------------
module lifo
   import lifo_pkg::*;
#(
   parameter int SIZEDATA  = DEF_SIZEDATA,
   parameter int DEPTHLIFO = DEF_DEPTHLIFO,
   parameter int BITSCONT  = cnt_width(DEPTHLIFO)
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                flush_i,
   input  logic                valid_i,
   input  logic [SIZEDATA-1:0] data_i,
   output logic                ready_o,
   output logic                valid_o,
   output logic [SIZEDATA-1:0] data_o,
   input  logic                ready_i,
   output logic [BITSCONT-1:0] count_o,
   output logic                full_o,
   output logic                empty_o
);

   localparam int ADDRW = addr_width(DEPTHLIFO);

   // -------------------------------------------------------------------------
   // Stack pointer and its decodes
   // -------------------------------------------------------------------------
   logic [BITSCONT-1:0] r_sp;
   logic [BITSCONT-1:0] w_sp_nxt;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_we;
   logic [ADDRW-1:0]    w_raddr;
   logic [ADDRW-1:0]    w_waddr;

   // Status is a pure decode of r_sp, so none of these outputs has any
   // combinational path from an input port.
   assign w_full  = (r_sp == BITSCONT'(DEPTHLIFO));
   assign w_empty = (r_sp == '0);

   assign full_o  = w_full;
   assign empty_o = w_empty;
   assign count_o = r_sp;
   assign ready_o = !w_full;
   assign valid_o = !w_empty;

   // Handshake decode. A push while full is dropped even if a pop fires in
   // the same cycle, because ready_o is taken from the current full state.
   assign w_push = valid_i && !w_full;
   assign w_pop  = ready_i && !w_empty;

   // -------------------------------------------------------------------------
   // Address selection
   // -------------------------------------------------------------------------
   // Top of stack lives at sp-1. When empty this wraps to the last entry,
   // which is harmless because data_o is a don't-care then.
   assign w_raddr = ADDRW'(r_sp - BITSCONT'(1));

   // Push-only writes the free slot at sp. Push with pop replaces the old
   // top in place at sp-1, leaving sp unchanged.
   assign w_waddr = w_pop ? w_raddr : ADDRW'(r_sp);

   // Flush wins over everything; suppressing the write keeps storage
   // untouched by a cycle whose push is being discarded anyway.
   assign w_we = w_push && !flush_i;

   // -------------------------------------------------------------------------
   // Next stack pointer
   // -------------------------------------------------------------------------
   // NOTE: every combinational output gets a default on the first line so no
   // path through the if-chain can leave it unassigned and infer a latch.
   always_comb begin
      w_sp_nxt = r_sp;
      if (flush_i) begin
         w_sp_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_sp_nxt = r_sp + BITSCONT'(1);
      end else if (w_pop && !w_push) begin
         w_sp_nxt = r_sp - BITSCONT'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs, independent of block ordering.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_sp <= '0;
      end else begin
         r_sp <= w_sp_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Storage
   // -------------------------------------------------------------------------
   lifo_mem #(
      .SIZEDATA  (SIZEDATA),
      .DEPTHLIFO (DEPTHLIFO),
      .ADDRW     (ADDRW)
   ) u_mem (
      .clk_i   (clk_i),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (data_i),
      .i_raddr (w_raddr),
      .o_rdata (data_o)
   );

   // -------------------------------------------------------------------------
   // Invariant: the pointer saturates at both ends and never wraps.
   // -------------------------------------------------------------------------
   a_sp_range : assert property (
      @(posedge clk_i) disable iff (!rstn_i) r_sp <= BITSCONT'(DEPTHLIFO)
   );

endmodule : lifo

// File: doc/lifo.md
LIFO -- requirements
Module: lifo

Interface
REQ-001 Parameter SIZEDATA, default 32, data word width in bits.
REQ-002 Parameter DEPTHLIFO, default 8, number of storage entries, SHALL be >= 2.
REQ-003 Parameter BITSCONT, default $clog2(DEPTHLIFO+1), occupancy counter width.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 flush_i  input  1  synchronous clear of all stored entries.
REQ-007 valid_i  input  1  push request.
REQ-008 data_i  input  SIZEDATA  push data.
REQ-009 ready_o  output  1  push accepted when high.
REQ-010 valid_o  output  1  top entry available for pop.
REQ-011 data_o  output  SIZEDATA  current top-of-stack word.
REQ-012 ready_i  input  1  pop request.
REQ-013 count_o  output  BITSCONT  current occupancy, 0..DEPTHLIFO.
REQ-014 full_o / empty_o  output  1 each  occupancy == DEPTHLIFO / occupancy == 0.

Function
REQ-015 Push fires when valid_i && ready_o; pop fires when valid_o && ready_i.
REQ-016 ready_o SHALL be !full_o, with no combinational dependence on ready_i or valid_i.
REQ-017 valid_o SHALL be !empty_o, with no combinational dependence on any input.
REQ-018 data_o SHALL be the entry at index sp-1 (show-ahead), where sp = occupancy.
REQ-019 data_o SHALL be a don't-care while empty_o is high; the bench must not check it.
REQ-020 Push only: write data_i to index sp and set sp = sp+1; the word appears on data_o the next cycle.
REQ-021 Pop only: set sp = sp-1; the popped word is the data_o value in the firing cycle.
REQ-022 Push and pop in the same cycle:
  - the popped word is the old top;
  - data_i overwrites index sp-1;
  - sp is unchanged.
REQ-023 Push while full (ready_o low) SHALL have no effect on storage or sp, including when a pop fires in the same cycle (that cycle is pop only).
REQ-024 A pop attempted while empty SHALL have no effect; sp never underflows.
REQ-025 flush_i high sets sp = 0 next cycle and overrides any push or pop in that cycle; storage contents need not be cleared.
REQ-026 Ordering is last-in-first-out: entries pop in reverse push order.
REQ-027 count_o, full_o and empty_o SHALL be decoded from sp only, with zero-cycle latency relative to sp.
REQ-028 sp arithmetic is unsigned BITSCONT-bit; there is no wrap-around, since sp is saturated by REQ-023 and REQ-024.

Reset
REQ-029 While rstn_i is low: sp = 0, so count_o = 0, empty_o = 1, full_o = 0, valid_o = 0 and ready_o = 1.
REQ-030 Storage array SHALL NOT be reset; data_o is undefined after reset until the first push.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously), without waiting for a clock edge.
REQ-032 The first push is accepted on the first rising edge after rstn_i deasserts.

Structure
REQ-033 Package lifo_pkg SHALL hold the default SIZEDATA and DEPTHLIFO localparams and a count-width helper function.
REQ-034 Sub-module lifo_mem SHALL implement the storage:
  - DEPTHLIFO x SIZEDATA register array;
  - one synchronous write port (we, waddr, wdata);
  - one combinational read port (raddr, rdata);
  - no reset.
REQ-035 The top level SHALL contain:
  - the sp register;
  - handshake decode;
  - write address select, sp for push-only and sp-1 for simultaneous push and pop.

Verification
REQ-036 Reset, then push 0xA1, 0xB2, 0xC3 with ready_i=0 -> count_o=3; data_o=0xC3; then pop x3 -> 0xC3, 0xB2, 0xA1; empty_o=1.
REQ-037 Push 8 words (DEPTHLIFO=8) -> full_o=1 and ready_o=0; a 9th push with valid_i=1 -> count_o stays 8 and top is unchanged.
REQ-038 At count 3 with top 0x33, push 0x77 and pop in the same cycle -> popped word 0x33; next data_o=0x77; count_o=3.
REQ-039 When full, valid_i=1 and ready_i=1 -> pop only; count_o goes 8 -> 7; the pushed word is not stored.
REQ-040 At count 5, flush_i=1 with a simultaneous push -> next cycle count_o=0 and empty_o=1; a later push of 0x5A -> data_o=0x5A.
REQ-041 Assert rstn_i low asynchronously at count 4, between clock edges -> empty_o=1 and count_o=0 without a clock edge; pop with ready_i=1 while empty -> no change.
